// File: rtl/trace_pkg.sv
// Shared types and constants for the store trace capture block.
package trace_pkg;

  localparam int TRACE_DEPTH   = 8;
  localparam int TRACE_STAMP_W = 16;
  localparam int DROP_CNT_W    = 8;

  // One captured store: where it went, what was written, and when.
  typedef struct packed {
    logic [31:0]              addr;
    logic [31:0]              data;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// The head word is read straight from the storage array, so rdata is valid
// in the cycle after the push that wrote it and has no input-to-output path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop needs data present; a push is accepted when there is room or
  // when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/store_trace_fifo.sv
// Passive observer of the core's store bus: timestamps every store, queues
// it in a small FIFO and streams it out over valid/ready. It never stalls
// the core, so stores that arrive while the queue is full are counted and
// discarded.
module store_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH   = TRACE_DEPTH,
  parameter int STAMP_W = TRACE_STAMP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [31:0]            dataadr,
  input  logic [31:0]            writedata,
  input  logic                   tr_ready,
  input  logic                   ovf_clear,
  output logic                   tr_valid,
  output logic [31:0]            tr_addr,
  output logic [31:0]            tr_data,
  output logic [STAMP_W-1:0]     tr_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  // Same layout as trace_entry_t, but sized by this instance's STAMP_W.
  typedef struct packed {
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  logic [STAMP_W-1:0] stamp;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop;

  // Free-running cycle stamp; wraps modulo 2^STAMP_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stamp <= '0;
    else       stamp <= stamp + STAMP_W'(1);
  end

  assign wr_entry.addr  = dataadr;
  assign wr_entry.data  = writedata;
  assign wr_entry.stamp = stamp;

  assign pop  = tr_valid && tr_ready;
  assign drop = memwrite && fifo_full && !pop;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (memwrite),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tr_valid = !fifo_empty;
  assign tr_addr  = rd_entry.addr;
  assign tr_data  = rd_entry.data;
  assign tr_stamp = rd_entry.stamp;

  // Sticky overflow and saturating drop count; a clear beats a same-cycle drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_store_trace_fifo.sv
// Self-checking bench for store_trace_fifo: directed table, hand sequences
// for reset/timestamp corners, and random traffic against a queue model.
module tb_store_trace_fifo;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;

  logic                   clk;
  logic                   reset;
  logic                   memwrite;
  logic [31:0]            dataadr;
  logic [31:0]            writedata;
  logic                   tr_ready;
  logic                   ovf_clear;
  logic                   tr_valid;
  logic [31:0]            tr_addr;
  logic [31:0]            tr_data;
  logic [STAMP_W-1:0]     tr_stamp;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [7:0]             drop_cnt;

  store_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tr_ready  (tr_ready),
    .ovf_clear (ovf_clear),
    .tr_valid  (tr_valid),
    .tr_addr   (tr_addr),
    .tr_data   (tr_data),
    .tr_stamp  (tr_stamp),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stores plus sticky flag and drop tally.
  typedef struct {
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [STAMP_W-1:0] stamp;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf;
  int          m_drop;
  int unsigned cycles_since_reset;
  int          checks;
  int          errors;

  // Cycle index since reset release: the stamp a store in this cycle receives.
  always @(posedge clk or posedge reset) begin
    if (reset) cycles_since_reset <= 0;
    else       cycles_since_reset <= cycles_since_reset + 1;
  end

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic        rdy;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_head;
    int          exp_count;
    logic        exp_ovf;
    int          exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Drive one cycle's inputs, advance the model by the rules, then wait
  // until the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d,
                               input logic rdy, input logic clr);
    bit   do_pop;
    bit   is_full;
    ent_t e;
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    tr_ready  = rdy;
    ovf_clear = clr;
    do_pop  = (q.size() > 0) && rdy;
    is_full = (q.size() == DEPTH);
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (mw && is_full && !do_pop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    if (do_pop) void'(q.pop_front());
    if (mw && (!is_full || do_pop)) begin
      e.addr  = a;
      e.data  = d;
      e.stamp = STAMP_W'(cycles_since_reset % (1 << STAMP_W));
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " valid"},    32'(tr_valid), 32'(q.size() > 0));
    checkValue({tag, " count"},    32'(count),    32'(q.size()));
    checkValue({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    checkValue({tag, " drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    if (q.size() > 0) begin
      checkValue({tag, " addr"},  tr_addr,         q[0].addr);
      checkValue({tag, " data"},  tr_data,         q[0].data);
      checkValue({tag, " stamp"}, 32'(tr_stamp),   32'(q[0].stamp));
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] prev_stamp;
    checks    = 0;
    errors    = 0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    tr_ready  = 1'b0;
    ovf_clear = 1'b0;
    modelReset();

    // Reset state while reset is held.
    reset = 1'b1;
    #21;
    checkValue("reset valid",    32'(tr_valid), 32'd0);
    checkValue("reset count",    32'(count),    32'd0);
    checkValue("reset overflow", 32'(overflow), 32'd0);
    checkValue("reset drop_cnt", 32'(drop_cnt), 32'd0);
    checkValue("reset addr",     tr_addr,       32'd0);
    checkValue("reset data",     tr_data,       32'd0);
    checkValue("reset stamp",    32'(tr_stamp), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Single store in cycle 5 after release, then pop it.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd84, 32'hFFFF7F02, 1'b0, 1'b0);
    checkValue("first valid", 32'(tr_valid), 32'd1);
    checkValue("first addr",  tr_addr,       32'd84);
    checkValue("first data",  tr_data,       32'hFFFF7F02);
    checkValue("first stamp", 32'(tr_stamp), 32'd5);
    checkValue("first count", 32'(count),    32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkValue("first pop valid", 32'(tr_valid), 32'd0);
    checkValue("first pop count", 32'(count),    32'd0);

    // Table: fill, overflow, push+pop while full, clear-with-drop, drain.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, 32'(4*i), 1'b0, 1'b0, 1'b1, 32'd0, i+1, 1'b0, 0};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b1, 32'd32, 1'b0, 1'b0, 1'b1, 32'd0, 8, 1'b1, 1});
    vecs.push_back('{1'b1, 32'd36, 1'b1, 1'b0, 1'b1, 32'd4, 8, 1'b1, 1});
    vecs.push_back('{1'b1, 32'd40, 1'b0, 1'b1, 1'b1, 32'd4, 8, 1'b0, 0});
    for (int k = 1; k <= 8; k++) begin
      v = '{1'b0, 32'd0, 1'b1, 1'b0, (k < 8), (k < 7) ? 32'(4*(k+1)) : 32'd36, 8-k, 1'b0, 0};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 0, 1'b0, 0});

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.mw, v.addr, ~v.addr, v.rdy, v.clr);
      checkValue($sformatf("vec%0d valid", i),    32'(tr_valid), 32'(v.exp_valid));
      checkValue($sformatf("vec%0d count", i),    32'(count),    32'(v.exp_count));
      checkValue($sformatf("vec%0d overflow", i), 32'(overflow), 32'(v.exp_ovf));
      checkValue($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(v.exp_drop));
      if (v.exp_valid) begin
        checkValue($sformatf("vec%0d addr", i), tr_addr, v.exp_head);
        checkValue($sformatf("vec%0d data", i), tr_data, ~v.exp_head);
      end
      checkOutput($sformatf("vec%0d model", i));
    end

    // Streaming: one store and one pop per cycle, stamps consecutive.
    prev_stamp = '0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4*i), 32'(i), 1'b1, 1'b0);
      checkValue($sformatf("stream%0d count<=1", i), 32'(count <= 1), 32'd1);
      checkValue($sformatf("stream%0d addr", i), tr_addr, 32'h100 + 32'(4*i));
      if (i > 0) checkValue($sformatf("stream%0d stamp step", i), 32'(tr_stamp), prev_stamp + 32'd1);
      prev_stamp = 32'(tr_stamp);
      checkOutput("stream model");
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stream drain");

    // Asynchronous reset mid-cycle with five entries queued.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 32'(i), 1'b0, 1'b0);
    checkValue("pre-reset count", 32'(count), 32'd5);
    memwrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkValue("async reset valid", 32'(tr_valid), 32'd0);
    checkValue("async reset count", 32'(count),    32'd0);
    checkValue("async reset stamp", 32'(tr_stamp), 32'd0);
    modelReset();
    #1 reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'h200, 32'h55, 1'b0, 1'b0);
    checkValue("post-reset stamp", 32'(tr_stamp), 32'd1);
    checkOutput("post-reset model");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, $urandom, $urandom,
                    $urandom_range(0, 99) < ((i < 200) ? 35 : 80),
                    $urandom_range(0, 31) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    // Drop counter saturation.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 270; i++) applyStimulus(1'b1, 32'(i), 32'(i), 1'b0, 1'b0);
    checkValue("saturated drop_cnt", 32'(drop_cnt), 32'd255);
    checkOutput("saturation model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
